// File: rtl/qbus_dma_arb.sv
// qbus_dma_arb: Q-bus DMA bus arbiter (CPU default master + NDEV requesters)
// Runs DMR/DMG/SACK/BBSY handshake and drives hold to the MCP-1621 bbusy input.
//
// Ports:
//   pin_clk   in          clock, all state on rising edge
//   pin_sr    in          synchronous active-high system reset
//   pin_dmr   in  [NDEV]  DMA requests, bit 0 highest fixed priority
//   pin_sack  in  [NDEV]  selection acknowledge per requester
//   pin_bbsy  in          bus busy (wired-OR of all masters)
//   pin_syn   in          CPU SYNC, CPU bus cycle in progress
//   pin_dmg   out [NDEV]  one-hot DMA grant
//   pin_hold  out         CPU must not start a new bus cycle
//   pin_gid   out [IW]    index of current/last granted requester
//   pin_own   out         DMA device owns the bus (SACK phase)
//   pin_nak   out         one-cycle pulse when a grant times out
//
// Optional build macro QBUS_ARB_RR_EN: round-robin winner selection
// instead of fixed lowest-index priority.

module qbus_dma_arb #(
  parameter int NDEV = 4,
  parameter int IW   = 2,
  parameter int TMO  = 16
) (
  input  logic            pin_clk,
  input  logic            pin_sr,
  input  logic [NDEV-1:0] pin_dmr,
  input  logic [NDEV-1:0] pin_sack,
  input  logic            pin_bbsy,
  input  logic            pin_syn,
  output logic [NDEV-1:0] pin_dmg,
  output logic            pin_hold,
  output logic [IW-1:0]   pin_gid,
  output logic            pin_own,
  output logic            pin_nak
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GRANT,
    S_OWN
  } state_t;

  state_t          r_state;
  logic [NDEV-1:0] r_dmg;
  logic            r_hold;
  logic [IW-1:0]   r_gid;
  logic            r_own;
  logic            r_nak;
  logic [7:0]      r_timer;

  logic            w_any;
  logic            w_go;
  logic [IW-1:0]   w_win;
  logic [NDEV-1:0] w_win_oh;
  logic [NDEV-1:0] w_gmask;
  logic            w_sack_g;
  logic            w_dmr_g;

  assign w_any    = |pin_dmr;
  assign w_go     = w_any & ~pin_syn & ~pin_bbsy;
  assign w_win_oh = NDEV'(1) << w_win;
  assign w_gmask  = NDEV'(1) << r_gid;
  // Only the granted requester's SACK/DMR matter; others are ignored.
  assign w_sack_g = |(pin_sack & w_gmask);
  assign w_dmr_g  = |(pin_dmr & w_gmask);

`ifdef QBUS_ARB_RR_EN
  logic [IW-1:0] r_last;

  // Search starts just after the last owner and wraps around.
  always_comb begin : p_rr
    int  v_idx;
    logic v_hit;
    w_win = '0;
    v_hit = 1'b0;
    v_idx = 0;
    for (int k = 0; k < NDEV; k++) begin
      v_idx = int'(r_last) + 1 + k;
      if (v_idx >= NDEV) v_idx = v_idx - NDEV;
      if (!v_hit && |(pin_dmr & (NDEV'(1) << v_idx))) begin
        w_win = IW'(v_idx);
        v_hit = 1'b1;
      end
    end
  end

  // Only a completed acquisition advances the pointer; timeouts do not.
  always_ff @(posedge pin_clk) begin
    if (pin_sr) begin
      r_last <= IW'(NDEV - 1);
    end else if (r_state == S_GRANT && w_sack_g) begin
      r_last <= r_gid;
    end
  end
`else
  // Lowest set index wins; scan high to low so the last hit is lowest.
  always_comb begin : p_fix
    w_win = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (|(pin_dmr & (NDEV'(1) << i))) w_win = IW'(i);
    end
  end
`endif

  always_ff @(posedge pin_clk) begin
    if (pin_sr) begin
      r_state <= S_IDLE;
      r_dmg   <= '0;
      r_hold  <= 1'b0;
      r_gid   <= '0;
      r_own   <= 1'b0;
      r_nak   <= 1'b0;
      r_timer <= '0;
    end else begin
      r_nak <= 1'b0;
      unique case (r_state)
        S_IDLE, S_WAIT: begin
          // Hold tracks pending requests; WAIT re-picks the winner each cycle.
          r_hold <= w_any;
          if (w_go) begin
            r_dmg   <= w_win_oh;
            r_gid   <= w_win;
            r_timer <= 8'(TMO - 1);
            r_state <= S_GRANT;
          end else if (w_any) begin
            r_state <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          r_hold <= 1'b1;
          if (w_sack_g) begin
            // SACK beats a simultaneous timeout.
            r_dmg   <= '0;
            r_own   <= 1'b1;
            r_state <= S_OWN;
          end else if (!w_dmr_g) begin
            r_dmg   <= '0;
            r_state <= S_IDLE;
          end else if (r_timer == 8'd0) begin
            r_dmg   <= '0;
            r_nak   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        S_OWN: begin
          r_hold <= 1'b1;
          r_dmg  <= '0;
          if (!w_sack_g && !pin_bbsy) begin
            r_own   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pin_dmg  = r_dmg;
  assign pin_hold = r_hold;
  assign pin_gid  = r_gid;
  assign pin_own  = r_own;
  assign pin_nak  = r_nak;

endmodule

// File: tb/tb_qbus_dma_arb.sv
// tb_qbus_dma_arb: directed scenarios plus randomized run against
// a cycle-level reference model of the Q-bus DMA arbiter.

module tb_qbus_dma_arb;

  localparam int NDEV = 4;
  localparam int IW   = 2;
  localparam int TMO  = 8;

  logic            clk = 1'b0;
  logic            sr = 1'b0;
  logic [NDEV-1:0] dmr = '0;
  logic [NDEV-1:0] sack = '0;
  logic            bbsy = 1'b0;
  logic            syn = 1'b0;
  logic [NDEV-1:0] dmg;
  logic            hold;
  logic [IW-1:0]   gid;
  logic            own;
  logic            nak;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: outputs plus grant age and round-robin pointer
  logic [NDEV-1:0] m_dmg = '0;
  logic            m_hold = 1'b0;
  logic [IW-1:0]   m_gid = '0;
  logic            m_own = 1'b0;
  logic            m_nak = 1'b0;
  int              m_age = 0;
  int              m_last = NDEV - 1;

  qbus_dma_arb #(.NDEV(NDEV), .IW(IW), .TMO(TMO)) dut (
    .pin_clk  (clk),
    .pin_sr   (sr),
    .pin_dmr  (dmr),
    .pin_sack (sack),
    .pin_bbsy (bbsy),
    .pin_syn  (syn),
    .pin_dmg  (dmg),
    .pin_hold (hold),
    .pin_gid  (gid),
    .pin_own  (own),
    .pin_nak  (nak)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [NDEV-1:0] r);
`ifdef QBUS_ARB_RR_EN
    for (int k = 0; k < NDEV; k++) begin
      int i;
      i = (m_last + 1 + k) % NDEV;
      if (r[i]) return i;
    end
`else
    for (int i = 0; i < NDEV; i++) begin
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic model_update();
    int w;
    if (sr) begin
      m_dmg = '0; m_hold = 1'b0; m_gid = '0;
      m_own = 1'b0; m_nak = 1'b0; m_age = 0;
      m_last = NDEV - 1;
    end else begin
      m_nak = 1'b0;
      if (m_own) begin
        m_hold = 1'b1;
        if (!sack[m_gid] && !bbsy) m_own = 1'b0;
      end else if (m_dmg != '0) begin
        m_hold = 1'b1;
        if (sack[m_gid]) begin
          m_dmg = '0; m_own = 1'b1; m_last = int'(m_gid);
        end else if (!dmr[m_gid]) begin
          m_dmg = '0;
        end else if (m_age == TMO) begin
          m_dmg = '0; m_nak = 1'b1;
        end else begin
          m_age++;
        end
      end else begin
        m_hold = (dmr != '0);
        if (dmr != '0 && !syn && !bbsy) begin
          w = pick(dmr);
          m_dmg = NDEV'(1) << w;
          m_gid = IW'(w);
          m_age = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain();
    dmr = '0; sack = '0; bbsy = 1'b0; syn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    sr = 1'b1;
    tick();
    sr = 1'b0;
    n_checks++;
    if ({dmg, hold, gid, own, nak} !== '0) begin
      n_fail++;
      $display("FAIL reset: dmg=%b hold=%b gid=%0d own=%b nak=%b, need all 0",
               dmg, hold, gid, own, nak);
    end
  endtask

  task automatic test_basic_grant();
    dmr = 4'b0001;
    tick();
    n_checks++;
    if (dmg !== 4'b0001 || hold !== 1'b1 || gid !== 2'd0) begin
      n_fail++;
      $display("FAIL basic_grant: dmg=%b hold=%b gid=%0d, need 0001 1 0", dmg, hold, gid);
    end
    repeat (2) tick();
    sack = 4'b0001; bbsy = 1'b1; dmr = '0;
    tick();
    n_checks++;
    if (dmg !== 4'b0000 || own !== 1'b1 || hold !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_own: dmg=%b own=%b hold=%b, need 0000 1 1", dmg, own, hold);
    end
    tick();
    sack = '0; bbsy = 1'b0;
    tick();
    n_checks++;
    if (own !== 1'b0 || dmg !== 4'b0000) begin
      n_fail++;
      $display("FAIL basic_release: own=%b dmg=%b, need 0 0000", own, dmg);
    end
    tick();
    n_checks++;
    if (hold !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold_drop: hold=%b, need 0", hold);
    end
  endtask

  task automatic test_cpu_deferral();
    dmr = 4'b0100; syn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (hold !== 1'b1 || dmg !== 4'b0000) begin
        n_fail++;
        $display("FAIL defer_c%0d: hold=%b dmg=%b, need 1 0000", c, hold, dmg);
      end
    end
    syn = 1'b0;
    tick();
    n_checks++;
    if (dmg !== 4'b0100 || gid !== 2'd2) begin
      n_fail++;
      $display("FAIL defer_grant: dmg=%b gid=%0d, need 0100 2", dmg, gid);
    end
    drain();
  endtask

  task automatic test_withdrawal();
    dmr = 4'b0100;
    tick();
    tick();
    dmr = '0;
    tick();
    n_checks++;
    if (dmg !== 4'b0000 || nak !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw: dmg=%b nak=%b, need 0000 0", dmg, nak);
    end
    tick();
    n_checks++;
    if (hold !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_hold: hold=%b, need 0", hold);
    end
  endtask

  task automatic test_priority();
    logic [NDEV-1:0] exp2;
    dmr = 4'b1010;
    tick();
    n_checks++;
    if (dmg !== 4'b0010 || gid !== 2'd1) begin
      n_fail++;
      $display("FAIL priority: dmg=%b gid=%0d, need 0010 1", dmg, gid);
    end
    sack = 4'b0010;
    tick();
    sack = '0;
    tick();
    tick();
`ifdef QBUS_ARB_RR_EN
    exp2 = 4'b1000;
`else
    exp2 = 4'b0010;
`endif
    n_checks++;
    if (dmg !== exp2) begin
      n_fail++;
      $display("FAIL priority_next: dmg=%b, need %b", dmg, exp2);
    end
    drain();
  endtask

  task automatic test_timeout();
    dmr = 4'b0001;
    tick();
    for (int k = 2; k <= TMO; k++) begin
      tick();
      n_checks++;
      if (dmg !== 4'b0001 || nak !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_hold_c%0d: dmg=%b nak=%b, need 0001 0", k, dmg, nak);
      end
    end
    tick();
    n_checks++;
    if (dmg !== 4'b0000 || nak !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_nak: dmg=%b nak=%b, need 0000 1", dmg, nak);
    end
    tick();
    n_checks++;
    if (dmg !== 4'b0001 || nak !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_regrant: dmg=%b nak=%b, need 0001 0", dmg, nak);
    end
    repeat (TMO - 1) tick();
    sack = 4'b0001;
    tick();
    n_checks++;
    if (own !== 1'b1 || nak !== 1'b0 || dmg !== 4'b0000) begin
      n_fail++;
      $display("FAIL tmo_sack_wins: own=%b nak=%b dmg=%b, need 1 0 0000", own, nak, dmg);
    end
    drain();
  endtask

  task automatic test_reset_mid_own();
    dmr = 4'b0010;
    tick();
    sack = 4'b0010; dmr = '0;
    tick();
    sr = 1'b1;
    tick();
    sr = 1'b0;
    n_checks++;
    if ({dmg, hold, gid, own, nak} !== '0) begin
      n_fail++;
      $display("FAIL reset_own: dmg=%b hold=%b gid=%0d own=%b nak=%b, need all 0",
               dmg, hold, gid, own, nak);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (dmg !== 4'b0000 || own !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_own_c%0d: dmg=%b own=%b, need 0000 0", c, dmg, own);
      end
    end
    drain();
  endtask

  task automatic test_random();
    sr = 1'b1;
    tick();
    sr = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(3) == 0) dmr = NDEV'($urandom);
      syn  = ($urandom_range(3) == 0);
      bbsy = ($urandom_range(4) == 0);
      sack = '0;
      if ($urandom_range(7) == 0) sack = NDEV'($urandom);
      if (m_dmg != '0 && $urandom_range(9) == 0) sack[m_gid] = 1'b1;
      if (m_own) sack[m_gid] = ($urandom_range(3) != 0);
      sr = ($urandom_range(99) == 0);
      tick();
      n_checks++;
      if (dmg !== m_dmg || hold !== m_hold || gid !== m_gid ||
          own !== m_own || nak !== m_nak) begin
        n_fail++;
        $display("FAIL random_c%0d: dmg=%b hold=%b gid=%0d own=%b nak=%b, need %b %b %0d %b %b",
                 c, dmg, hold, gid, own, nak, m_dmg, m_hold, m_gid, m_own, m_nak);
      end
      n_checks++;
      if ($countones(dmg) > 1) begin
        n_fail++;
        $display("FAIL random_onehot_c%0d: dmg=%b, need at most one bit", c, dmg);
      end
    end
    sr = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_basic_grant();
    test_cpu_deferral();
    test_withdrawal();
    test_priority();
    test_timeout();
    test_reset_mid_own();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
